mod_mul_serial: RTL
===================

MOD_MUL_SERIAL -- requirements
Module: mod_mul_serial

Interface
REQ-001 Parameter W, default 256, sets the operand, modulus and result width in bits; W SHALL be at least 4.
REQ-002 Parameter CW, default $clog2(W), sets the width of the bit counter.
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  asserted when operands X, Y and M are presented.
REQ-006 Port in_ready  output  1  high when the block can accept an operation.
REQ-007 Port X  input  W  multiplicand.
REQ-008 Port Y  input  W  multiplier.
REQ-009 Port M  input  W  runtime modulus, not a constant.
REQ-010 Port Q  output  W  result, equal to (X*Y) mod M.
REQ-011 Port out_valid  output  1  Q is valid.
REQ-012 Port out_ready  input  1  the consumer accepts Q.
REQ-013 Port out_err  output  1  operand-range error; present only with the macro in REQ-030.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, when in_valid and in_ready are both high at a clock edge:
- X, Y and M are registered;
- the accumulator R is cleared to 0;
- the counter is loaded with W-1;
- the state goes to RUN.
REQ-016 Each RUN cycle SHALL process one bit of X, MSB first:
- T = 2R + (X[cnt] ? Y : 0), computed W+2 bits wide;
- R <= T - k*M, where k in {0,1,2} is the smallest value giving a result below M;
- both compares against M and 2M complete in the same cycle.
REQ-017 When cnt = 0, the RUN cycle SHALL write the final R to Q and go to DONE; otherwise cnt decrements.
REQ-018 out_valid SHALL rise exactly W cycles after the accepting edge; for example, with W = 8, acceptance at edge 0 gives out_valid high after edge 8.
REQ-019 In DONE:
- out_valid = 1 and Q is held stable until out_ready is high at an edge;
- at that edge the state goes to IDLE and out_valid drops;
- in_ready rises in the following cycle.
REQ-020 in_valid SHALL be ignored in RUN and DONE, and input changes during RUN SHALL NOT affect the result.
REQ-021 Minimum spacing between accepted operations SHALL be W+2 cycles (accept, W RUN cycles, DONE handshake).
REQ-022 Precondition: M >= 2, X < M and Y < M; Q SHALL then be exact for all values, including X = 0, Y = 0 and X = Y = M-1.
REQ-023 If the precondition is violated and REQ-030 is not compiled in, the value of Q is unspecified, but the handshake and latency SHALL be unchanged.
REQ-024 Q SHALL change only at the final RUN cycle or at reset.

Reset
REQ-025 Reset SHALL take priority over all other activity at a clock edge.
REQ-026 Reset SHALL set the state to IDLE, and set Q = 0, out_valid = 0, out_err = 0, R = 0 and cnt = 0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is deasserted.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation; no out_valid pulse SHALL follow for the aborted operation.
REQ-029 X, Y and M registers need no reset.

Configuration
REQ-030 Macro MOD_MUL_SERIAL_RANGE_CHECK_EN controls operand range checking.
- Defined: at the accepting edge, out_err is latched as (M < 2) || (X >= M) || (Y >= M). If the flag is set, RUN still runs W cycles, and then Q = 0 and out_err = 1 are presented with out_valid. out_err is valid only while out_valid is high and clears when leaving DONE.
- Undefined: the out_err port and its logic are absent, and REQ-023 applies.

Verification
REQ-031 W=8, M=13, X=7, Y=9 -> out_valid 8 cycles after acceptance with Q=11; in_ready is 0 throughout RUN and DONE.
REQ-032 W=8, back-to-back operations, with out_ready held 1:
- (X=12, Y=12, M=13) -> Q=1;
- (X=250, Y=250, M=251) -> Q=1;
- (X=0, Y=200, M=251) -> Q=0;
- second acceptance occurs 10 cycles after the first.
REQ-033 W=8, M=13, X=7, Y=9 with out_ready held low 5 cycles after out_valid rises -> Q=11 and out_valid stay stable for all 5 cycles; one cycle after out_ready=1, out_valid=0 and in_ready=1.
REQ-034 W=8, reset pulsed 3 cycles after acceptance -> next cycle: out_valid=0, Q=0, in_ready=1; a new operation (X=5, Y=6, M=7) -> Q=2.
REQ-035 W=256, M=2^255-19, X=1, Y=M-1 -> Q=M-1 after 256 cycles; X=M-1, Y=M-1 -> Q=1.
REQ-036 Macro defined, W=8, M=13, X=13, Y=1 -> out_valid after 8 cycles with out_err=1 and Q=0; the following valid operation gives out_err=0.

Source files
------------

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier: Q = (X*Y) mod M, one bit of X per cycle, MSB first.
// Optional operand range check is compiled in with MOD_MUL_SERIAL_RANGE_CHECK_EN.
module mod_mul_serial #(
  parameter int unsigned W  = 256,
  parameter int unsigned CW = $clog2(W)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [W-1:0] M,
  output logic [W-1:0] Q,
  output logic         out_valid,
  input  logic         out_ready
`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
  ,
  output logic         out_err
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   x_q, y_q, m_q;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W+1:0]   t, m1, m2, rn_wide;
  logic [W-1:0]   r_next;
  logic           unused_hi;
  logic           accept;

  assign accept = (state_q == StIdle) && in_valid;

  // With R < M and Y < M, T < 3M, so at most two subtractions of M are needed.
  always_comb begin
    m1 = {2'b00, m_q};
    m2 = {1'b0, m_q, 1'b0};
    t  = {1'b0, r_q, 1'b0} + (x_q[cnt_q] ? {2'b00, y_q} : '0);
    if (t < m1) begin
      rn_wide = t;
    end else if (t < m2) begin
      rn_wide = t - m1;
    end else begin
      rn_wide = t - m2;
    end
  end

  assign r_next    = rn_wide[W-1:0];
  assign unused_hi = ^rn_wide[W+1:W];

`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
  logic err_q, err_d;
  assign out_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          r_d     = '0;
          cnt_d   = CW'(W - 1);
          state_d = StRun;
`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
          err_d   = (M < W'(2)) || (X >= M) || (Y >= M);
`endif
        end
      end
      StRun: begin
        r_d = r_next;
        if (cnt_q == '0) begin
`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
          q_d = err_q ? '0 : r_next;
`else
          q_d = r_next;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      r_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
`ifdef MOD_MUL_SERIAL_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Operand registers carry no reset; they are only read in RUN after a load.
  always_ff @(posedge clock) begin
    if (accept) begin
      x_q <= X;
      y_q <= Y;
      m_q <= M;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Q         = q_q;

endmodule
